// File: rtl/pact_core_cmd_dispatcher_if.sv
// Command valid/ready channel from the PACT control front-end into the dispatcher.
// master = front-end side, slave = dispatcher side.
interface pact_core_cmd_dispatcher_if #(
    parameter int BW_SUBOP     = 4,
    parameter int BW_IMMEDIATE = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [BW_SUBOP-1:0]     cmd_subop;
    logic                    cmd_is_float;
    logic [BW_IMMEDIATE-1:0] cmd_immediate;

    modport master (
        output cmd_valid, cmd_subop, cmd_is_float, cmd_immediate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_subop, cmd_is_float, cmd_immediate,
        output cmd_ready
    );
endinterface

// File: rtl/pact_core_cmd_dispatcher.sv
// Buffers PACT core commands in a small FIFO and issues them one at a time over
// the node's start/finish handshake, with operands held stable between issues.
module pact_core_cmd_dispatcher #(
    parameter int BW_SUBOP      = 4,
    parameter int BW_IMMEDIATE  = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int BW_DONE_COUNT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic                           flush_i,
    pact_core_cmd_dispatcher_if.slave      cmd,
    output logic                           start_o,
    input  logic                           finish_i,
    output logic [BW_SUBOP-1:0]            subop_o,
    output logic                           operation_is_float_o,
    output logic [BW_IMMEDIATE-1:0]        immediate_value_o,
    output logic                           busy_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
    output logic [BW_DONE_COUNT-1:0]       done_count_o,
    output logic                           dropped_idle_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = BW_SUBOP + 1 + BW_IMMEDIATE;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                   state_q, state_d;
    logic [EW-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [BW_SUBOP-1:0]      subop_q;
    logic                     float_q;
    logic [BW_IMMEDIATE-1:0]  imm_q;
    logic [BW_DONE_COUNT-1:0] done_q;
    logic                     dropped_q;

    logic          full, push, pop, load, drop, done_inc;
    logic [EW-1:0] head;

    assign full          = (count_q == CW'(FIFO_DEPTH));
    assign cmd.cmd_ready = !full && !flush_i && !rst;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign head          = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load     = 1'b0;
        drop     = 1'b0;
        done_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The node never finishes subop 0, so it is retired here instead of issued.
                if (enable_i && count_q != '0 && !flush_i) begin
                    pop = 1'b1;
                    if (head[EW-1 -: BW_SUBOP] != '0) begin
                        load    = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        drop     = 1'b1;
                        done_inc = 1'b1;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (finish_i) begin
                    done_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (flush_i)           count_d = '0;
        else if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd.cmd_subop, cmd.cmd_is_float, cmd.cmd_immediate};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            subop_q   <= '0;
            float_q   <= 1'b0;
            imm_q     <= '0;
            done_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dropped_q <= drop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            // No push is accepted during flush, so wr_ptr_q is the post-flush head.
            if (flush_i)  rd_ptr_q <= wr_ptr_q;
            else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (load) begin
                subop_q <= head[EW-1 -: BW_SUBOP];
                float_q <= head[BW_IMMEDIATE];
                imm_q   <= head[BW_IMMEDIATE-1:0];
            end
            if (done_inc) done_q <= done_q + 1'b1;
        end
    end

    assign start_o              = (state_q == S_ISSUE);
    assign subop_o              = subop_q;
    assign operation_is_float_o = float_q;
    assign immediate_value_o    = imm_q;
    assign busy_o               = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count_o         = count_q;
    assign done_count_o         = done_q;
    assign dropped_idle_o       = dropped_q;
endmodule

// File: tb/tb_pact_core_cmd_dispatcher.sv
// Randomized and directed bench for pact_core_cmd_dispatcher: a cycle model of queue
// occupancy and completions predicts issues into a scoreboard drained on each start.
module tb_pact_core_cmd_dispatcher;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]  subop;
        logic        fl;
        logic [31:0] imm;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, flush, finish;
    logic        start, op_float, busy, dropped;
    logic [3:0]  subop;
    logic [31:0] imm;
    logic [2:0]  fifo_count;
    logic [15:0] done_count;

    pact_core_cmd_dispatcher_if #(.BW_SUBOP(4), .BW_IMMEDIATE(32)) cmd_if ();

    pact_core_cmd_dispatcher #(
        .BW_SUBOP(4), .BW_IMMEDIATE(32), .FIFO_DEPTH(DEPTH), .BW_DONE_COUNT(16)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .flush_i(flush), .cmd(cmd_if),
        .start_o(start), .finish_i(finish), .subop_o(subop),
        .operation_is_float_o(op_float), .immediate_value_o(imm), .busy_o(busy),
        .fifo_count_o(fifo_count), .done_count_o(done_count), .dropped_idle_o(dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued commands, one command in flight, completion count.
    cmd_t        mq[$];
    cmd_t        exp_q[$];
    logic        m_inflight = 1'b0, m_start_now = 1'b0, m_drop_now = 1'b0;
    logic [15:0] m_done = '0;
    int          n_starts = 0, n_drops = 0;

    always @(negedge clk) begin
        logic e_ready, n_start, n_drop;
        cmd_t c;
        if (rst) begin
            mq.delete(); exp_q.delete();
            m_inflight = 1'b0; m_start_now = 1'b0; m_drop_now = 1'b0; m_done = '0;
        end
        e_ready = !rst && (mq.size() < DEPTH) && !flush;
        chk("cmd_ready", cmd_if.cmd_ready, e_ready);
        chk("fifo_count", fifo_count, mq.size());
        chk("busy", busy, m_inflight || mq.size() != 0);
        chk("done_count", done_count, m_done);
        chk("start", start, m_start_now);
        chk("dropped_idle", dropped, m_drop_now);
        if (!rst) begin
            n_start = 1'b0; n_drop = 1'b0;
            if (m_inflight) begin
                if (!m_start_now && finish) begin
                    m_inflight = 1'b0;
                    m_done++;
                end
            end else if (enable && mq.size() > 0 && !flush) begin
                c = mq.pop_front();
                m_done += (c.subop == 0) ? 16'd1 : 16'd0;
                if (c.subop == 0) n_drop = 1'b1;
                else begin
                    m_inflight = 1'b1;
                    n_start    = 1'b1;
                    exp_q.push_back(c);
                end
            end
            if (cmd_if.cmd_valid && e_ready)
                mq.push_back('{cmd_if.cmd_subop, cmd_if.cmd_is_float, cmd_if.cmd_immediate});
            if (flush) mq.delete();
            m_start_now = n_start;
            m_drop_now  = n_drop;
        end
    end

    // Scoreboard monitor: each start pops the predicted issue; operands must then hold.
    cmd_t held = '{4'h0, 1'b0, 32'h0};
    always @(negedge clk) begin
        if (rst) held = '{4'h0, 1'b0, 32'h0};
        else begin
            if (dropped) n_drops++;
            if (start) begin
                n_starts++;
                if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
                else held = exp_q.pop_front();
            end
        end
        chk("subop", subop, held.subop);
        chk("operation_is_float", op_float, held.fl);
        chk("immediate_value", imm, held.imm);
    end

    // Node model: 0 = never finish, 1 = finish whenever asked, 2 = random.
    int fmode = 0;
    initial finish = 1'b0;
    always @(posedge clk) begin
        #1;
        case (fmode)
            1:       finish = 1'b1;
            2:       finish = ($urandom_range(0, 2) == 0);
            default: finish = 1'b0;
        endcase
    end

    task automatic push(input logic [3:0] s, input logic f, input logic [31:0] i);
        logic acc;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_subop = s;
        cmd_if.cmd_is_float = f; cmd_if.cmd_immediate = i;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); acc = cmd_if.cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                cmd_if.cmd_valid = 1'b0;
                return;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        chk("push_timeout", 1, 0);
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (!busy && !start) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("quiet_timeout", 1, 0);
    endtask

    initial begin
        int s0, d0;
        logic [15:0] last;
        logic wrapped;
        rst = 1'b1; enable = 1'b0; flush = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_subop = '0;
        cmd_if.cmd_is_float = 1'b0; cmd_if.cmd_immediate = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single command, node finishes right after start.
        fmode = 1; enable = 1'b1;
        push(4'd1, 1'b0, 32'h1000_0040);
        wait_quiet();
        chk("t1_done", done_count, 16'd1);
        chk("t1_imm_held", imm, 32'h1000_0040);

        // Back-to-back fill with the node stalled; the sixth push waits for a pop.
        fmode = 0; s0 = n_starts;
        for (int k = 0; k < 5; k++) push(4'(k + 1), k[0], 32'hA000_0000 + k);
        fork
            push(4'd7, 1'b1, 32'hA000_0005);
            begin
                repeat (2) @(negedge clk);
                chk("t2_full_ready", cmd_if.cmd_ready, 1'b0);
                chk("t2_full_count", fifo_count, 3'd4);
                @(posedge clk); #1 fmode = 1;
            end
        join
        wait_quiet();
        chk("t2_starts", n_starts - s0, 6);
        chk("t2_done", done_count, 16'd7);

        // Idle subop between two real commands.
        s0 = n_starts; d0 = n_drops; enable = 1'b0;
        push(4'd2, 1'b0, 32'h11); push(4'd0, 1'b1, 32'h22); push(4'd2, 1'b1, 32'h33);
        enable = 1'b1;
        wait_quiet();
        chk("t3_starts", n_starts - s0, 2);
        chk("t3_drops", n_drops - d0, 1);
        chk("t3_done", done_count, 16'd10);

        // Flush during WAIT of the first of three; a push in the flush cycle is refused.
        fmode = 0; s0 = n_starts;
        push(4'd3, 1'b0, 32'h100); push(4'd4, 1'b0, 32'h200); push(4'd5, 1'b0, 32'h300);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_subop = 4'd6; cmd_if.cmd_immediate = 32'h400;
        @(negedge clk) chk("t4_flush_ready", cmd_if.cmd_ready, 1'b0);
        @(posedge clk); #1 flush = 1'b0; cmd_if.cmd_valid = 1'b0;
        @(negedge clk) chk("t4_flush_count", fifo_count, 3'd0);
        fmode = 1;
        wait_quiet();
        chk("t4_starts", n_starts - s0, 1);
        chk("t4_done", done_count, 16'd11);

        // Enable gating.
        enable = 1'b0; s0 = n_starts;
        push(4'd8, 1'b1, 32'h5555); push(4'd9, 1'b0, 32'h6666);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t5_gated_busy", busy, 1'b1);
        chk("t5_gated_starts", n_starts - s0, 0);
        @(posedge clk); #1 enable = 1'b1;
        wait_quiet();
        chk("t5_starts", n_starts - s0, 2);

        // Randomized traffic with random enable, flush and finish.
        fmode = 2;
        for (int k = 0; k < 1500; k++) begin
            cmd_if.cmd_valid     = $urandom_range(0, 1);
            cmd_if.cmd_subop     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cmd_if.cmd_is_float  = $urandom_range(0, 1);
            cmd_if.cmd_immediate = $urandom;
            enable = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        cmd_if.cmd_valid = 1'b0; flush = 1'b0; enable = 1'b1;
        wait_quiet();

        // done_count wrap via a stream of idle-subop commands.
        fmode = 1; wrapped = 1'b0; last = m_done;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_subop = 4'd0;
        for (int k = 0; k < 70000 && !wrapped; k++) begin
            @(posedge clk); #1;
            if (m_done < last) wrapped = 1'b1;
            last = m_done;
        end
        cmd_if.cmd_valid = 1'b0;
        wait_quiet();
        chk("t6_wrapped", wrapped, 1'b1);

        // Async reset while waiting on the node, then normal operation.
        fmode = 0;
        push(4'd3, 1'b1, 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t7_rst_start", start, 0);
        chk("t7_rst_subop", subop, 0);
        chk("t7_rst_float", op_float, 0);
        chk("t7_rst_imm", imm, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_count", fifo_count, 0);
        chk("t7_rst_done", done_count, 0);
        chk("t7_rst_dropped", dropped, 0);
        chk("t7_rst_ready", cmd_if.cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; fmode = 1;
        push(4'd5, 1'b0, 32'h0BAD_F00D);
        wait_quiet();
        chk("t7_done", done_count, 16'd1);
        chk("t7_imm", imm, 32'h0BAD_F00D);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
